// File: rtl/mb_bist_driver.sv
// BIST driver/checker for the pipelined Booth multiplier: issues operands, predicts and checks products.
// Define MB_BIST_LFSR_EN for LFSR operands; otherwise operands come from the vector index.
module mb_bist_driver #(
    parameter int WIDTH       = 8,
    parameter int LATENCY     = 4,
    parameter int NUM_VECTORS = 10000,
    parameter int IDXW        = 16
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 start,
    output logic [WIDTH-1:0]     mx,
    output logic [WIDTH-1:0]     my,
    input  logic [2*WIDTH-1:0]   product,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [IDXW-1:0]      err_count,
    output logic [IDXW-1:0]      first_err_idx
);
    localparam int PW  = 2 * WIDTH;
    localparam int DCW = $clog2(LATENCY + 1) + 1;
    localparam logic [IDXW-1:0] LAST_IDX   = IDXW'(NUM_VECTORS - 1);
    localparam logic [DCW-1:0]  DRAIN_LAST = DCW'(LATENCY);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [IDXW-1:0]   idx;
    logic [DCW-1:0]    drain_cnt;
    logic [PW-1:0]     vec;
    logic              accept;
    logic              mismatch;

    // Head stage is loaded together with mx/my; LATENCY more stages line it up with product.
    logic              head_v;
    logic [IDXW-1:0]   head_idx;
    logic [PW-1:0]     head_exp;
    logic              pipe_v   [LATENCY];
    logic [IDXW-1:0]   pipe_idx [LATENCY];
    logic [PW-1:0]     pipe_exp [LATENCY];

    assign accept   = start && (state == IDLE || state == DONE);
    assign busy     = (state == RUN) || (state == DRAIN);
    assign done     = (state == DONE);
    assign pass     = done && (err_count == '0);
    assign mismatch = pipe_v[LATENCY-1] && (pipe_exp[LATENCY-1] != product);

`ifdef MB_BIST_LFSR_EN
    // Shift-right Fibonacci taps: bit 0 leaves, the XOR of the tapped bits enters at the top.
    localparam logic [63:0] TAPS_ALL = (PW == 8)  ? 64'h1D :
                                       (PW == 24) ? 64'h87 :
                                       (PW == 32) ? 64'hC000_0401 : 64'h2D;
    localparam logic [PW-1:0] TAPS = TAPS_ALL[PW-1:0];

    logic [PW-1:0] lfsr;

    always_ff @(posedge CLK) begin
        if (!RST || accept) begin
            lfsr <= PW'(1);
        end else if (state == RUN) begin
            lfsr <= {^(lfsr & TAPS), lfsr[PW-1:1]};
        end
    end

    assign vec = lfsr;
`else
    localparam int VW = (IDXW > PW) ? IDXW : PW;

    logic [VW-1:0] idx_ext;

    assign idx_ext = VW'(idx);
    assign vec     = idx_ext[PW-1:0];
`endif

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE, DONE: if (start) state_nxt = RUN;
            RUN:        if (idx == LAST_IDX) state_nxt = DRAIN;
            DRAIN:      if (drain_cnt == DRAIN_LAST) state_nxt = DONE;
            default:    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            mx            <= '0;
            my            <= '0;
            idx           <= '0;
            drain_cnt     <= '0;
            head_v        <= 1'b0;
            head_idx      <= '0;
            head_exp      <= '0;
            err_count     <= '0;
            first_err_idx <= '1;
            for (int i = 0; i < LATENCY; i++) begin
                pipe_v[i]   <= 1'b0;
                pipe_idx[i] <= '0;
                pipe_exp[i] <= '0;
            end
        end else begin
            mx        <= '0;
            my        <= '0;
            head_v    <= 1'b0;
            head_idx  <= '0;
            head_exp  <= '0;
            drain_cnt <= '0;
            if (state == RUN) begin
                mx       <= vec[WIDTH-1:0];
                my       <= vec[PW-1:WIDTH];
                head_v   <= 1'b1;
                head_idx <= idx;
                head_exp <= PW'(vec[WIDTH-1:0]) * PW'(vec[PW-1:WIDTH]);
                if (idx != LAST_IDX) idx <= idx + IDXW'(1);
            end
            if (state == DRAIN) drain_cnt <= drain_cnt + DCW'(1);
            pipe_v[0]   <= head_v;
            pipe_idx[0] <= head_idx;
            pipe_exp[0] <= head_exp;
            for (int i = 1; i < LATENCY; i++) begin
                pipe_v[i]   <= pipe_v[i-1];
                pipe_idx[i] <= pipe_idx[i-1];
                pipe_exp[i] <= pipe_exp[i-1];
            end
            if (accept) begin
                err_count     <= '0;
                first_err_idx <= '1;
                idx           <= '0;
            end else if (mismatch) begin
                if (err_count != '1) err_count <= err_count + IDXW'(1);
                if (err_count == '0) first_err_idx <= pipe_idx[LATENCY-1];
            end
        end
    end
endmodule

// File: tb/tb_mb_bist_driver.sv
// Scoreboard bench for mb_bist_driver against a behavioural multiplier with injectable faults.
// Build with MB_BIST_LFSR_EN defined to exercise the LFSR operand variant.
`timescale 1ns/1ps
module tb_mb_bist_driver;
    localparam int W       = 8;
    localparam int PW      = 2 * W;
    localparam int LAT     = 4;
    localparam int IW      = 16;
`ifdef MB_BIST_LFSR_EN
    localparam int NV      = 1000;
`else
    localparam int NV      = 300;
`endif
    localparam int RUN_LEN = NV + LAT + 1;
    localparam logic [IW-1:0] NONE = 16'hFFFF;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          start = 1'b0;
    logic [W-1:0]  mx;
    logic [W-1:0]  my;
    logic [PW-1:0] product;
    logic          busy;
    logic          done;
    logic          pass;
    logic [IW-1:0] err_count;
    logic [IW-1:0] first_err_idx;

    mb_bist_driver #(
        .WIDTH(W), .LATENCY(LAT), .NUM_VECTORS(NV), .IDXW(IW)
    ) dut (
        .CLK(CLK), .RST(RST), .start(start), .mx(mx), .my(my),
        .product(product), .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .first_err_idx(first_err_idx)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errs   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_errs++;
        $display("FAIL %s: got no event, expected one at %0t", name, $time);
    endtask

    // Behavioural multiplier: product valid LAT edges after the operands.
    int            model_lat = LAT;
    bit            stuck0 = 1'b0;
    logic [PW-1:0] mpipe [8];

    always @(posedge CLK) begin
        mpipe[0] <= PW'(mx) * PW'(my);
        for (int i = 1; i < 8; i++) mpipe[i] <= mpipe[i-1];
    end

    always_comb begin
        product = mpipe[3'(model_lat - 1)];
        if (stuck0) product[0] = 1'b0;
    end

    typedef struct {
        logic [IW-1:0] err;
        logic [IW-1:0] first;
        logic          pass;
    } res_t;

    logic [PW-1:0] op_q [$];
    res_t          res_q [$];
    logic [PW-1:0] op_want;
    res_t          res_want;

    // Reference run tracker: cycles since the edge that accepted start.
    bit running = 1'b0;
    int run_cyc = 0;
    bit fin = 1'b0;

    always @(posedge CLK) begin
        fin <= 1'b0;
        if (!RST) begin
            running <= 1'b0;
            run_cyc <= 0;
        end else if (running) begin
            run_cyc <= run_cyc + 1;
            if (run_cyc + 1 == RUN_LEN) begin
                running <= 1'b0;
                fin     <= 1'b1;
            end
        end else if (start) begin
            running <= 1'b1;
            run_cyc <= 0;
        end
    end

    always @(negedge CLK) begin
        if (RST && running) begin
            check("busy", 32'(busy), 32'd1);
            check("done_early", 32'(done), 32'd0);
            if (run_cyc == 0) begin
                check("err_cleared", 32'(err_count), 32'd0);
                check("first_cleared", 32'(first_err_idx), 32'(NONE));
            end
            if (run_cyc >= 1 && run_cyc <= NV) begin
                if (op_q.size() == 0) begin
                    fail_now("operand_queue");
                end else begin
                    op_want = op_q.pop_front();
                    check("operands", 32'({my, mx}), 32'(op_want));
                end
            end else begin
                check("operands_zero", 32'({my, mx}), 32'd0);
            end
        end
        if (RST && fin) begin
            check("busy_end", 32'(busy), 32'd0);
            check("done", 32'(done), 32'd1);
            if (res_q.size() == 0) begin
                fail_now("result_queue");
            end else begin
                res_want = res_q.pop_front();
                check("err_count", 32'(err_count), 32'(res_want.err));
                check("first_err_idx", 32'(first_err_idx), 32'(res_want.first));
                check("pass", 32'(pass), 32'(res_want.pass));
            end
        end
    end

    task automatic push_ops();
        logic [PW-1:0] l = 16'h0001;
        for (int k = 0; k < NV; k++) begin
`ifdef MB_BIST_LFSR_EN
            op_q.push_back(l);
            l = {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
`else
            op_q.push_back(PW'(k));
`endif
        end
    endtask

    task automatic expect_run(input logic [IW-1:0] e_err, input logic [IW-1:0] e_first,
                              input logic e_pass);
        res_t r;
        r.err   = e_err;
        r.first = e_first;
        r.pass  = e_pass;
        push_ops();
        res_q.push_back(r);
    endtask

    task automatic kick();
        @(negedge CLK);
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
    endtask

    task automatic wait_result(input string tag);
        int t = 0;
        while (res_q.size() != 0 && t < RUN_LEN + 20) begin
            @(negedge CLK);
            t++;
        end
        if (res_q.size() != 0) begin
            fail_now(tag);
            res_q.delete();
            op_q.delete();
        end
        @(negedge CLK);
    endtask

    task automatic wait_cyc(input int c);
        int t = 0;
        while (run_cyc != c && t < RUN_LEN) begin
            @(negedge CLK);
            t++;
        end
        if (run_cyc != c) fail_now("wait_cycle");
    endtask

    task automatic run(input string tag, input bit sa, input int lat,
                       input logic [IW-1:0] e_err, input logic [IW-1:0] e_first,
                       input logic e_pass);
        stuck0    = sa;
        model_lat = lat;
        expect_run(e_err, e_first, e_pass);
        kick();
        wait_result(tag);
    endtask

    task automatic check_reset();
        check("rst_mx", 32'(mx), 32'd0);
        check("rst_my", 32'(my), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_pass", 32'(pass), 32'd0);
        check("rst_err", 32'(err_count), 32'd0);
        check("rst_first", 32'(first_err_idx), 32'(NONE));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish, expected one");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (10) @(negedge CLK);
        check_reset();
        RST = 1'b1;
        repeat (3) @(negedge CLK);
        check_reset();

        run("ideal", 1'b0, LAT, 16'd0, NONE, 1'b1);
`ifndef MB_BIST_LFSR_EN
        // Odd mx with my=1 (idx 257..299) loses bit 0.
        run("stuck0", 1'b1, LAT, 16'd22, 16'd257, 1'b0);
`endif

        // start pulses inside RUN and DRAIN must not disturb the run.
        stuck0    = 1'b0;
        model_lat = LAT;
        expect_run(16'd0, NONE, 1'b1);
        kick();
        wait_cyc(5);
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        wait_cyc(NV + 2);
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        wait_result("ignore_start");

`ifndef MB_BIST_LFSR_EN
        // One-cycle-late multiplier: every nonzero product from idx 257 on is wrong.
        run("late", 1'b0, LAT + 1, 16'd43, 16'd257, 1'b0);
`endif
        run("rerun", 1'b0, LAT, 16'd0, NONE, 1'b1);

        // Reset while vector 7 is on the operands.
        expect_run(16'd0, NONE, 1'b1);
        kick();
        wait_cyc(8);
        RST = 1'b0;
        @(negedge CLK);
        check_reset();
        RST = 1'b1;
        op_q.delete();
        res_q.delete();
        repeat (3) @(negedge CLK);
        run("after_reset", 1'b0, LAT, 16'd0, NONE, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end
endmodule
